// File: rtl/alu_op_issue_if.sv
// Handshake bundle between decode and the ALU issue stage: instruction fields in,
// decoded ALU control out.
interface alu_op_issue_if #(
  parameter int TAG_W = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [6:0]       in_opcode;
  logic [2:0]       in_funct3;
  logic [6:0]       in_funct7;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [2:0]       out_opc;
  logic             out_is_branch;
  logic             out_br_on_zero;
  logic             out_illegal;
  logic [TAG_W-1:0] out_tag;

  modport master (
    output in_valid, in_opcode, in_funct3, in_funct7, in_tag, out_ready,
    input  in_ready, out_valid, out_opc, out_is_branch, out_br_on_zero, out_illegal, out_tag
  );

  modport slave (
    input  in_valid, in_opcode, in_funct3, in_funct7, in_tag, out_ready,
    output in_ready, out_valid, out_opc, out_is_branch, out_br_on_zero, out_illegal, out_tag
  );
endinterface

// File: rtl/alu_op_issue.sv
// RV32I decode-and-issue stage producing ALU op code and branch sense, one registered op per instruction.
// Optional ALU_ISSUE_SKID_EN adds a skid register so in_ready comes straight from a flop.
module alu_op_issue #(
  parameter int TAG_W = 8
) (
  input logic         clk,
  input logic         rst_n,
  alu_op_issue_if.slave bus
);
  localparam logic [2:0] OPC_ADD  = 3'b000;
  localparam logic [2:0] OPC_SUB  = 3'b001;
  localparam logic [2:0] OPC_AND  = 3'b010;
  localparam logic [2:0] OPC_OR   = 3'b011;
  localparam logic [2:0] OPC_XOR  = 3'b100;
  localparam logic [2:0] OPC_SLT  = 3'b101;
  localparam logic [2:0] OPC_SLTU = 3'b110;
  localparam logic [2:0] OPC_ILL  = 3'b111;

  typedef struct packed {
    logic [2:0]       opc;
    logic             is_branch;
    logic             br_on_zero;
    logic             illegal;
    logic [TAG_W-1:0] tag;
  } op_t;

  op_t  dec_op;
  op_t  out_q, out_d;
  logic out_valid_q, out_valid_d;
  logic in_ready;
  logic in_fire, out_fire;

  // Decoder defaults to the illegal encoding; legal cases overwrite the op fields.
  always_comb begin
    dec_op            = '0;
    dec_op.opc        = OPC_ILL;
    dec_op.illegal    = 1'b1;
    dec_op.tag        = bus.in_tag;
    unique case (bus.in_opcode)
      7'b0110011: begin
        if (bus.in_funct7 == 7'b0000000) begin
          dec_op.illegal = 1'b0;
          case (bus.in_funct3)
            3'b000:  dec_op.opc = OPC_ADD;
            3'b111:  dec_op.opc = OPC_AND;
            3'b110:  dec_op.opc = OPC_OR;
            3'b100:  dec_op.opc = OPC_XOR;
            3'b010:  dec_op.opc = OPC_SLT;
            3'b011:  dec_op.opc = OPC_SLTU;
            default: dec_op.illegal = 1'b1;
          endcase
        end else if (bus.in_funct7 == 7'b0100000 && bus.in_funct3 == 3'b000) begin
          dec_op.illegal = 1'b0;
          dec_op.opc     = OPC_SUB;
        end
      end
      7'b0010011: begin
        dec_op.illegal = 1'b0;
        case (bus.in_funct3)
          3'b000:  dec_op.opc = OPC_ADD;
          3'b111:  dec_op.opc = OPC_AND;
          3'b110:  dec_op.opc = OPC_OR;
          3'b100:  dec_op.opc = OPC_XOR;
          3'b010:  dec_op.opc = OPC_SLT;
          3'b011:  dec_op.opc = OPC_SLTU;
          default: dec_op.illegal = 1'b1;
        endcase
      end
      7'b0000011, 7'b0100011, 7'b1100111, 7'b0110111: begin
        dec_op.illegal = 1'b0;
        dec_op.opc     = OPC_ADD;
      end
      7'b1100011: begin
        dec_op.illegal   = 1'b0;
        dec_op.is_branch = 1'b1;
        case (bus.in_funct3)
          3'b000: begin dec_op.opc = OPC_SUB;  dec_op.br_on_zero = 1'b1; end
          3'b001: begin dec_op.opc = OPC_SUB;  dec_op.br_on_zero = 1'b0; end
          3'b100: begin dec_op.opc = OPC_SLT;  dec_op.br_on_zero = 1'b0; end
          3'b101: begin dec_op.opc = OPC_SLT;  dec_op.br_on_zero = 1'b1; end
          3'b110: begin dec_op.opc = OPC_SLTU; dec_op.br_on_zero = 1'b0; end
          3'b111: begin dec_op.opc = OPC_SLTU; dec_op.br_on_zero = 1'b1; end
          default: begin
            dec_op.illegal   = 1'b1;
            dec_op.is_branch = 1'b0;
          end
        endcase
      end
      default: ;
    endcase
    if (dec_op.illegal) dec_op.opc = OPC_ILL;
  end

  assign in_fire  = bus.in_valid && in_ready;
  assign out_fire = out_valid_q && bus.out_ready;

`ifdef ALU_ISSUE_SKID_EN
  op_t  skid_q, skid_d;
  logic skid_valid_q, skid_valid_d;
  logic in_ready_q, in_ready_d;

  assign in_ready = in_ready_q;

  // in_ready_q accepts one op after out_ready drops; that op lands in skid.
  always_comb begin
    out_d        = out_q;
    out_valid_d  = out_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!out_valid_q || out_fire) begin
      if (skid_valid_q) begin
        out_d        = skid_q;
        out_valid_d  = 1'b1;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = in_fire;
        if (in_fire) out_d = dec_op;
      end
    end else if (in_fire) begin
      skid_d       = dec_op;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end
`else
  assign in_ready = !out_valid_q || bus.out_ready;

  always_comb begin
    out_d       = out_q;
    out_valid_d = out_valid_q;
    if (in_fire) begin
      out_d       = dec_op;
      out_valid_d = 1'b1;
    end else if (out_fire) begin
      out_valid_d = 1'b0;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = out_valid_q;
  assign bus.out_opc        = out_q.opc;
  assign bus.out_is_branch  = out_q.is_branch;
  assign bus.out_br_on_zero = out_q.br_on_zero;
  assign bus.out_illegal    = out_q.illegal;
  assign bus.out_tag        = out_q.tag;
endmodule
